// File: rtl/port_lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : port_lookup_pkg
// Description : Shared definitions for the static output-port lookup stage.
//               Holds the FSM state encoding, the IOQ header field layout,
//               the default IOQ stage number and the source-to-destination
//               port map.
// Revision    : 1.0 - initial release
// ============================================================================
package port_lookup_pkg;

  // Lookup FSM states.
  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // IOQ module header field layout (LSB positions, all fields 16 bits wide).
  localparam int IOQ_FIELD_W      = 16;
  localparam int IOQ_BYTE_LEN_LSB = 0;
  localparam int IOQ_SRC_LSB      = 16;
  localparam int IOQ_WORD_LEN_LSB = 32;
  localparam int IOQ_DST_LSB      = 48;

  // Control value marking the IOQ module header.
  localparam logic [7:0] IOQ_STAGE_NUM_DEFAULT = 8'hFF;

  // Fixed map: MAC k (src 2k) goes to MAC k+1 (wrapping), CPU k (src 2k+1)
  // goes to MAC k. The result is the one-hot destination port field.
  function automatic logic [15:0] src_to_dst(input logic [15:0] src,
                                             input int unsigned num_mac_ports);
    int unsigned kk;
    int unsigned bit_idx;
    logic [15:0] dst;
    kk = {16'd0, src} >> 1;
    if (src[0]) begin
      bit_idx = 2 * kk;
    end else begin
      bit_idx = 2 * ((kk + 1) % num_mac_ports);
    end
    dst = 16'd0;
    if (bit_idx < 32'd16) begin
      dst[bit_idx[3:0]] = 1'b1;
    end
    return dst;
  endfunction

endpackage : port_lookup_pkg
`default_nettype wire

// File: rtl/small_fifo.sv
`default_nettype none
// ============================================================================
// Module      : small_fifo
// Description : Shallow synchronous FIFO with a registered read port. The
//               word addressed by rd_en appears on dout after the clock edge
//               that performs the read. nearly_full asserts one entry short
//               of full so the writer gets one cycle of slack.
// Revision    : 1.0 - initial release
// ============================================================================
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int                    DEPTH       = 1 << MAX_DEPTH_BITS;
  localparam int                    CNT_W       = MAX_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_NEARLY  = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign nearly_full = (count_q >= CNT_NEARLY);
  assign dout        = dout_q;

  // Pointer, occupancy and read-data next-state logic.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates all reads.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule : small_fifo
`default_nettype wire

// File: rtl/static_port_lookup.sv
`default_nettype none
// ============================================================================
// Module      : static_port_lookup
// Description : Output-port lookup stage. Rewrites the destination field of
//               each packet's IOQ header from a fixed source-to-destination
//               map, drops packets whose source port is out of range and
//               forwards all other words unchanged. Input is buffered in a
//               4-deep FIFO; rdy/wr flow control on both sides.
//               Optional build macro PORT_LOOKUP_STATS_EN enables the
//               forwarded/dropped packet counters (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module static_port_lookup
  import port_lookup_pkg::*;
#(
  parameter int         DATA_WIDTH    = 64,
  parameter int         CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter logic [7:0] IOQ_STAGE_NUM = IOQ_STAGE_NUM_DEFAULT,
  parameter int         NUM_MAC_PORTS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pkt_fwd_cnt,
  output logic [31:0]           pkt_drop_cnt
);

  localparam int                    FIFO_W    = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL  = CTRL_WIDTH'(IOQ_STAGE_NUM);
  localparam logic [15:0]           SRC_LIMIT = 16'(2 * NUM_MAC_PORTS);

  // --------------------------------------------------------------------------
  // Input buffer
  // --------------------------------------------------------------------------
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_nearly_full;
  logic              fifo_rd;

  small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign in_rdy = !fifo_nearly_full;

  // --------------------------------------------------------------------------
  // Word decode. The FIFO read port is registered, so the word being
  // processed this cycle is the one read on the previous edge (rd_valid_q).
  // --------------------------------------------------------------------------
  logic [CTRL_WIDTH-1:0] word_ctrl;
  logic [DATA_WIDTH-1:0] word_data;
  logic [15:0]           word_src;
  logic                  src_valid;
  logic [15:0]           mapped_dst;

  assign word_ctrl  = fifo_dout[FIFO_W-1 -: CTRL_WIDTH];
  assign word_data  = fifo_dout[DATA_WIDTH-1:0];
  assign word_src   = word_data[IOQ_SRC_LSB +: IOQ_FIELD_W];
  assign src_valid  = (word_src < SRC_LIMIT);
  assign mapped_dst = src_to_dst(word_src, NUM_MAC_PORTS);

  // --------------------------------------------------------------------------
  // Lookup FSM and output register
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  drop_seen_q, drop_seen_d;   // data word seen in DROP
  logic                  rd_valid_q, rd_valid_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  fwd_evt;
  logic                  drop_evt;

  // Next state and output word for the word currently leaving the FIFO.
  always_comb begin
    state_d     = state_q;
    drop_seen_d = drop_seen_q;
    out_wr_d    = 1'b0;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    fwd_evt     = 1'b0;
    drop_evt    = 1'b0;
    if (rd_valid_q) begin
      case (state_q)
        ST_HDR: begin
          if (word_ctrl == IOQ_CTRL) begin
            if (src_valid) begin
              out_wr_d   = 1'b1;
              out_ctrl_d = word_ctrl;
              out_data_d = word_data;
              out_data_d[IOQ_DST_LSB +: IOQ_FIELD_W] = mapped_dst;
            end else begin
              state_d     = ST_DROP;
              drop_seen_d = 1'b0;
            end
          end else begin
            out_wr_d   = 1'b1;
            out_ctrl_d = word_ctrl;
            out_data_d = word_data;
            if (word_ctrl == '0) begin
              state_d = ST_PKT;
            end
          end
        end
        ST_PKT: begin
          out_wr_d   = 1'b1;
          out_ctrl_d = word_ctrl;
          out_data_d = word_data;
          if (word_ctrl != '0) begin
            state_d = ST_HDR;
            fwd_evt = 1'b1;
          end
        end
        ST_DROP: begin
          if (word_ctrl == '0) begin
            drop_seen_d = 1'b1;
          end else if (drop_seen_q) begin
            state_d  = ST_HDR;
            drop_evt = 1'b1;
          end
        end
        default: begin
          state_d = ST_HDR;
        end
      endcase
    end
  end

  // Read decision uses the state the next word will be processed in, so a
  // word fetched while out_rdy=0 can only ever land in DROP and be discarded.
  always_comb begin
    fifo_rd    = !fifo_empty && ((state_d == ST_DROP) || out_rdy);
    rd_valid_d = fifo_rd;
  end

  // FSM state, read-pipeline flag and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HDR;
      drop_seen_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      out_wr_q    <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      drop_seen_q <= drop_seen_d;
      rd_valid_q  <= rd_valid_d;
      out_wr_q    <= out_wr_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;

  // --------------------------------------------------------------------------
  // Packet statistics
  // --------------------------------------------------------------------------
`ifdef PORT_LOOKUP_STATS_EN
  logic [31:0] pkt_fwd_cnt_q, pkt_fwd_cnt_d;
  logic [31:0] pkt_drop_cnt_q, pkt_drop_cnt_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    pkt_fwd_cnt_d  = pkt_fwd_cnt_q;
    pkt_drop_cnt_d = pkt_drop_cnt_q;
    if (fwd_evt) begin
      pkt_fwd_cnt_d = pkt_fwd_cnt_q + 32'd1;
    end
    if (drop_evt) begin
      pkt_drop_cnt_d = pkt_drop_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_fwd_cnt_q  <= 32'd0;
      pkt_drop_cnt_q <= 32'd0;
    end else begin
      pkt_fwd_cnt_q  <= pkt_fwd_cnt_d;
      pkt_drop_cnt_q <= pkt_drop_cnt_d;
    end
  end

  assign pkt_fwd_cnt  = pkt_fwd_cnt_q;
  assign pkt_drop_cnt = pkt_drop_cnt_q;
`else
  logic unused_evt;
  assign unused_evt   = fwd_evt ^ drop_evt;
  assign pkt_fwd_cnt  = 32'd0;
  assign pkt_drop_cnt = 32'd0;
`endif

  // FIFO full is implied by nearly_full for flow control purposes.
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule : static_port_lookup
`default_nettype wire

// File: tb/tb_static_port_lookup.sv
`default_nettype none
// ============================================================================
// Module      : tb_static_port_lookup
// Description : Directed self-checking bench for static_port_lookup.
//               Counter expectations follow the PORT_LOOKUP_STATS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_static_port_lookup;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [31:0] pkt_fwd_cnt;
  logic [31:0] pkt_drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  logic [71:0] got_q[$];
  logic [71:0] exp_q[$];

  always #5 clk = ~clk;

  static_port_lookup dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .pkt_fwd_cnt  (pkt_fwd_cnt),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  // Capture every output write, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset && out_wr) got_q.push_back({out_ctrl, out_data});
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ioq(input logic [15:0] dst, input logic [15:0] wlen,
                                      input logic [15:0] src, input logic [15:0] blen);
    return {dst, wlen, src, blen};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef PORT_LOOKUP_STATS_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  // Write one word once in_rdy allows it.
  task automatic push(input logic [7:0] c, input logic [63:0] d);
    int budget;
    budget = 100;
    while (!in_rdy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: in_rdy observed=0 expected=1");
    end
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    @(negedge clk);
    in_wr   = 1'b0;
  endtask

  // Write a word that is expected to come out as d_exp.
  task automatic fwd(input logic [7:0] c, input logic [63:0] d, input logic [63:0] d_exp);
    exp_q.push_back({c, d_exp});
    push(c, d);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 72'bx, exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_fwd_cnt"},  72'(pkt_fwd_cnt),  72'(exp_cnt(exp_fwd)));
    check({tag, "_drop_cnt"}, 72'(pkt_drop_cnt), 72'(exp_cnt(exp_drop)));
  endtask

  initial begin
    reset   = 1'b0;
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_out_wr",   72'(out_wr),   72'(0));
    check("rst_out_data", 72'(out_data), 72'(0));
    check("rst_out_ctrl", 72'(out_ctrl), 72'(0));
    check("rst_in_rdy",   72'(in_rdy),   72'(1));
    check_counters("rst");
    reset = 1'b1;
    @(negedge clk);

    // MAC0 packet with latency measurement on the header word.
    exp_q.push_back({8'hFF, ioq(16'h0004, 16'd4, 16'd0, 16'd40)});
    in_ctrl = 8'hFF;
    in_data = ioq(16'h0000, 16'd4, 16'd0, 16'd40);
    in_wr   = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
    check("lat_edge_n",  72'(out_wr), 72'(0));
    @(negedge clk);
    check("lat_edge_n1", 72'(out_wr), 72'(0));
    @(negedge clk);
    check("lat_edge_n2", 72'(out_wr), 72'(1));
    check("lat_hdr",     72'(out_data), 72'(64'h0004_0004_0000_0028));
    fwd(8'h00, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
    fwd(8'h00, 64'h0202_0202_0202_0202, 64'h0202_0202_0202_0202);
    fwd(8'h00, 64'h0303_0303_0303_0303, 64'h0303_0303_0303_0303);
    fwd(8'h08, 64'h0404_0404_0404_0404, 64'h0404_0404_0404_0404);
    repeat (8) @(negedge clk);
    check_stream("mac0");
    exp_fwd = 1;
    check_counters("mac0");

    // CPU2 packet preceded by another module header, then MAC3 (wrap-around).
    fwd(8'h40, 64'h00AB_CDEF_0000_0001, 64'h00AB_CDEF_0000_0001);
    fwd(8'hFF, ioq(16'h0000, 16'd3, 16'd5, 16'd24), ioq(16'h0010, 16'd3, 16'd5, 16'd24));
    fwd(8'h00, 64'hDEAD_BEEF_0000_0005, 64'hDEAD_BEEF_0000_0005);
    fwd(8'h04, 64'h0000_0000_0000_0FE5, 64'h0000_0000_0000_0FE5);
    fwd(8'hFF, ioq(16'h00F0, 16'd3, 16'd6, 16'd20), ioq(16'h0001, 16'd3, 16'd6, 16'd20));
    fwd(8'h00, 64'hFFFF_0000_1234_5678, 64'hFFFF_0000_1234_5678);
    fwd(8'h00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    fwd(8'h10, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF);
    repeat (8) @(negedge clk);
    check_stream("cpu2_mac3");
    exp_fwd = 3;
    check_counters("cpu2_mac3");

    // Invalid source 9 is dropped whole; following CPU3 packet is intact.
    push(8'hFF, ioq(16'h0002, 16'd4, 16'd9, 16'd32));
    push(8'h00, 64'h9999_9999_9999_9999);
    push(8'h00, 64'h8888_8888_8888_8888);
    push(8'h01, 64'h7777_7777_7777_7777);
    fwd(8'hFF, ioq(16'h0000, 16'd2, 16'd7, 16'd16), ioq(16'h0040, 16'd2, 16'd7, 16'd16));
    fwd(8'h00, 64'h0707_0707_0707_0707, 64'h0707_0707_0707_0707);
    fwd(8'h20, 64'h0000_0000_0000_0707, 64'h0000_0000_0000_0707);
    repeat (8) @(negedge clk);
    check_stream("drop_then_cpu3");
    exp_fwd  = 4;
    exp_drop = 1;
    check_counters("drop");

    // Back-pressure: out_rdy toggles every cycle across a 10-word packet.
    fork
      begin
        fwd(8'hFF, ioq(16'h0000, 16'd9, 16'd1, 16'd72), ioq(16'h0001, 16'd9, 16'd1, 16'd72));
        for (int i = 0; i < 8; i++) begin
          fwd(8'h00, 64'h5A00_0000_0000_0000 + 64'(i), 64'h5A00_0000_0000_0000 + 64'(i));
        end
        fwd(8'h80, 64'h0000_0000_0000_A5A5, 64'h0000_0000_0000_A5A5);
      end
      begin
        repeat (60) begin
          @(negedge clk);
          out_rdy = ~out_rdy;
        end
      end
    join
    out_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check_stream("bp10");
    exp_fwd = 5;

    // Stalled output: in_rdy tracks FIFO occupancy, one extra write allowed.
    out_rdy = 1'b0;
    @(negedge clk);
    fwd(8'hFF, ioq(16'h0000, 16'd4, 16'd2, 16'd32), ioq(16'h0010, 16'd4, 16'd2, 16'd32));
    fwd(8'h00, 64'h1111_0000_0000_0001, 64'h1111_0000_0000_0001);
    check("in_rdy_at2", 72'(in_rdy), 72'(1));
    fwd(8'h00, 64'h1111_0000_0000_0002, 64'h1111_0000_0000_0002);
    check("in_rdy_at3", 72'(in_rdy), 72'(0));
    check("stall_no_wr", 72'(out_wr), 72'(0));
    exp_q.push_back({8'h00, 64'h1111_0000_0000_0003});
    in_ctrl = 8'h00;
    in_data = 64'h1111_0000_0000_0003;
    in_wr   = 1'b1;
    @(negedge clk);
    in_wr = 1'b0;
    check("in_rdy_at4", 72'(in_rdy), 72'(0));
    out_rdy = 1'b1;
    fwd(8'h02, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_1111);
    repeat (10) @(negedge clk);
    check_stream("fill");
    exp_fwd = 6;
    check_counters("fill");

    // Reset pulse after the 2nd data word of a packet.
    fwd(8'hFF, ioq(16'h0000, 16'd5, 16'd0, 16'd40), ioq(16'h0004, 16'd5, 16'd0, 16'd40));
    fwd(8'h00, 64'h2222_0000_0000_0001, 64'h2222_0000_0000_0001);
    fwd(8'h00, 64'h2222_0000_0000_0002, 64'h2222_0000_0000_0002);
    repeat (5) @(negedge clk);
    check_stream("pre_reset");
    reset = 1'b0;
    #1;
    exp_fwd  = 0;
    exp_drop = 0;
    check("mid_rst_out_wr",   72'(out_wr),   72'(0));
    check("mid_rst_out_data", 72'(out_data), 72'(0));
    check("mid_rst_out_ctrl", 72'(out_ctrl), 72'(0));
    check("mid_rst_in_rdy",   72'(in_rdy),   72'(1));
    check_counters("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fwd(8'hFF, ioq(16'h0000, 16'd2, 16'd4, 16'd16), ioq(16'h0040, 16'd2, 16'd4, 16'd16));
    fwd(8'h00, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0001);
    fwd(8'h08, 64'h0000_0000_0000_3333, 64'h0000_0000_0000_3333);
    repeat (8) @(negedge clk);
    check_stream("post_reset");
    exp_fwd = 1;
    check_counters("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_static_port_lookup
`default_nettype wire
